// File: rtl/mips_exec_ctrl.sv
// Multi-cycle MIPS execute controller: HALT/FETCH/DECODE/EXEC1/EXEC2 sequencer, decoder and ALU.
// Define MIPS_EXEC_MULTDIV_EN to decode MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO.
module mips_exec_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        waitrequest,
    input  logic        pc_zero,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [2:0]  state,
    output logic        active,
    output logic [31:0] alu_result,
    output logic        zero,
    output logic        memread,
    output logic        memwrite,
    output logic        inwrite,
    output logic        pcwrite,
    output logic        pctoadd,
    output logic        regwrite,
    output logic        regdst,
    output logic        memtoreg,
    output logic        alusrc,
    output logic        jump,
    output logic        branch,
    output logic        regtojump,
    output logic        link,
    output logic        loadimmed,
    output logic        hitoreg,
    output logic        lotoreg,
    output logic        div_mult_en,
    output logic        div_mult_signed,
    output logic [1:0]  div_mult_op,
    output logic [2:0]  extend_op
);

    typedef enum logic [2:0] {
        S_HALT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC1  = 3'd3,
        S_EXEC2  = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_op_t;

    typedef struct packed {
        logic       regwrite;
        logic       regdst;
        logic       alusrc;
        logic       zext;
        logic       var_shift;
        logic       memtoreg;
        logic       jump;
        logic       branch;
        logic       regtojump;
        logic       link;
        logic       loadimmed;
        logic       is_load;
        logic       is_store;
        logic [2:0] extend_op;
        alu_op_t    alu_op;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0a;
    localparam logic [5:0] OP_SLTIU  = 6'h0b;
    localparam logic [5:0] OP_ANDI   = 6'h0c;
    localparam logic [5:0] OP_ORI    = 6'h0d;
    localparam logic [5:0] OP_XORI   = 6'h0e;
    localparam logic [5:0] OP_LUI    = 6'h0f;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_LHU    = 6'h25;
    localparam logic [5:0] OP_SW     = 6'h2b;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_JALR = 6'h09;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2a;
    localparam logic [5:0] F_SLTU = 6'h2b;

    localparam logic [4:0] RT_BLTZ   = 5'h00;
    localparam logic [4:0] RT_BGEZ   = 5'h01;
    localparam logic [4:0] RT_BLTZAL = 5'h10;
    localparam logic [4:0] RT_BGEZAL = 5'h11;

`ifdef MIPS_EXEC_MULTDIV_EN
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU  = 6'h1b;

    logic       dm_en;
    logic       dm_signed;
    logic       dm_hi;
    logic       dm_lo;
    logic [1:0] dm_op;
`endif

    state_t      state_q;
    state_t      state_d;
    logic        active_d;
    ctrl_t       dec;
    logic        taken;
    logic        in_fetch;
    logic        in_ex1;
    logic        in_ex2;
    logic        go;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rt_field;
    logic [31:0] imm_s;
    logic [31:0] imm_z;
    logic        rs_neg;
    logic        rs_is_zero;
    alu_op_t     op_sel;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic        unused_rs_field;

    assign opcode          = instr[31:26];
    assign funct           = instr[5:0];
    assign rt_field        = instr[20:16];
    assign imm_s           = {{16{instr[15]}}, instr[15:0]};
    assign imm_z           = {16'h0000, instr[15:0]};
    assign rs_neg          = rs_data[31];
    assign rs_is_zero      = (rs_data == 32'h0);
    // Register numbers are resolved by the datapath, not here.
    assign unused_rs_field = ^instr[25:21];

    // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_HALT;
            active  <= 1'b0;
        end else begin
            state_q <= state_d;
            active  <= active_d;
        end
    end

    // A zero PC halts the machine ahead of any advance, even while stalled.
    always_comb begin
        state_d  = state_q;
        active_d = active;
        if (pc_zero && (state_q != S_HALT)) begin
            state_d  = S_HALT;
            active_d = 1'b0;
        end else if (!waitrequest) begin
            case (state_q)
                S_HALT: begin
                    state_d  = S_FETCH;
                    active_d = 1'b1;
                end
                S_FETCH:  state_d = S_DECODE;
                S_DECODE: state_d = S_EXEC1;
                S_EXEC1:  state_d = S_EXEC2;
                S_EXEC2:  state_d = S_FETCH;
                default:  state_d = S_HALT;
            endcase
        end
    end

    // NOTE: every decode output gets a default first, so no path through the case infers a latch.
    always_comb begin
        dec        = '0;
        dec.alu_op = ALU_ADD;
        taken      = 1'b0;
`ifdef MIPS_EXEC_MULTDIV_EN
        dm_en      = 1'b0;
        dm_signed  = 1'b0;
        dm_hi      = 1'b0;
        dm_lo      = 1'b0;
        dm_op      = 2'b00;
`endif
        case (opcode)
            OP_RTYPE: begin
                dec.regdst   = 1'b1;
                dec.regwrite = 1'b1;
                case (funct)
                    F_SLL:  dec.alu_op = ALU_SLL;
                    F_SRL:  dec.alu_op = ALU_SRL;
                    F_SRA:  dec.alu_op = ALU_SRA;
                    F_SLLV: begin dec.alu_op = ALU_SLL; dec.var_shift = 1'b1; end
                    F_SRLV: begin dec.alu_op = ALU_SRL; dec.var_shift = 1'b1; end
                    F_SRAV: begin dec.alu_op = ALU_SRA; dec.var_shift = 1'b1; end
                    F_ADDU: dec.alu_op = ALU_ADD;
                    F_SUBU: dec.alu_op = ALU_SUB;
                    F_AND:  dec.alu_op = ALU_AND;
                    F_OR:   dec.alu_op = ALU_OR;
                    F_XOR:  dec.alu_op = ALU_XOR;
                    F_NOR:  dec.alu_op = ALU_NOR;
                    F_SLT:  dec.alu_op = ALU_SLT;
                    F_SLTU: dec.alu_op = ALU_SLTU;
                    F_JR: begin
                        dec.regdst    = 1'b0;
                        dec.regwrite  = 1'b0;
                        dec.jump      = 1'b1;
                        dec.regtojump = 1'b1;
                    end
                    F_JALR: begin
                        dec.jump      = 1'b1;
                        dec.regtojump = 1'b1;
                    end
`ifdef MIPS_EXEC_MULTDIV_EN
                    F_MFHI: dm_hi = 1'b1;
                    F_MFLO: dm_lo = 1'b1;
                    F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO: begin
                        dec.regdst   = 1'b0;
                        dec.regwrite = 1'b0;
                        dm_en        = 1'b1;
                        dm_signed    = (funct == F_MULT) || (funct == F_DIV);
                        case (funct)
                            F_MULT, F_MULTU: dm_op = 2'b00;
                            F_DIV, F_DIVU:   dm_op = 2'b01;
                            F_MTHI:          dm_op = 2'b10;
                            default:         dm_op = 2'b11;
                        endcase
                    end
`endif
                    default: begin
                        dec.regdst   = 1'b0;
                        dec.regwrite = 1'b0;
                    end
                endcase
            end
            OP_REGIMM: begin
                dec.branch = 1'b1;
                dec.alu_op = ALU_SUB;
                case (rt_field)
                    RT_BLTZ: taken = rs_neg;
                    RT_BGEZ: taken = !rs_neg;
                    RT_BLTZAL, RT_BGEZAL: begin
                        taken        = (rt_field == RT_BLTZAL) ? rs_neg : !rs_neg;
                        dec.link     = 1'b1;
                        dec.regwrite = 1'b1;
                    end
                    default: dec.branch = 1'b0;
                endcase
            end
            OP_J:   dec.jump = 1'b1;
            OP_JAL: begin
                dec.jump     = 1'b1;
                dec.link     = 1'b1;
                dec.regwrite = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                dec.branch = 1'b1;
                dec.alu_op = ALU_SUB;
                case (opcode)
                    OP_BEQ:  taken = (rs_data == rt_data);
                    OP_BNE:  taken = (rs_data != rt_data);
                    OP_BLEZ: taken = rs_neg || rs_is_zero;
                    default: taken = !rs_neg && !rs_is_zero;
                endcase
            end
            OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                case (opcode)
                    OP_SLTI:  dec.alu_op = ALU_SLT;
                    OP_SLTIU: dec.alu_op = ALU_SLTU;
                    OP_ANDI:  begin dec.alu_op = ALU_AND; dec.zext = 1'b1; end
                    OP_ORI:   begin dec.alu_op = ALU_OR;  dec.zext = 1'b1; end
                    OP_XORI:  begin dec.alu_op = ALU_XOR; dec.zext = 1'b1; end
                    OP_LUI:   begin dec.alu_op = ALU_LUI; dec.loadimmed = 1'b1; end
                    default:  dec.alu_op = ALU_ADD;
                endcase
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.is_load  = 1'b1;
                case (opcode)
                    OP_LB:   dec.extend_op = 3'b111;
                    OP_LBU:  dec.extend_op = 3'b110;
                    OP_LH:   dec.extend_op = 3'b101;
                    OP_LHU:  dec.extend_op = 3'b100;
                    default: dec.memtoreg  = 1'b1;
                endcase
            end
            OP_SW: begin
                dec.alusrc   = 1'b1;
                dec.is_store = 1'b1;
            end
            default: ;
        endcase
    end

    // EXEC1 always forms the effective address rs + signext(imm).
    always_comb begin
        op_sel = in_ex1 ? ALU_ADD : dec.alu_op;
        op_b   = rt_data;
        if (in_ex1 || (dec.alusrc && !dec.zext)) op_b = imm_s;
        else if (dec.alusrc)                     op_b = imm_z;
        shamt = dec.var_shift ? rs_data[4:0] : instr[10:6];
        case (op_sel)
            ALU_ADD:  alu_result = rs_data + op_b;
            ALU_SUB:  alu_result = rs_data - op_b;
            ALU_AND:  alu_result = rs_data & op_b;
            ALU_OR:   alu_result = rs_data | op_b;
            ALU_XOR:  alu_result = rs_data ^ op_b;
            ALU_NOR:  alu_result = ~(rs_data | op_b);
            ALU_SLT:  alu_result = {31'h0, $signed(rs_data) < $signed(op_b)};
            ALU_SLTU: alu_result = {31'h0, rs_data < op_b};
            ALU_SLL:  alu_result = rt_data << shamt;
            ALU_SRL:  alu_result = rt_data >> shamt;
            ALU_SRA:  alu_result = $signed(rt_data) >>> shamt;
            default:  alu_result = {instr[15:0], 16'h0000};
        endcase
    end

    assign zero = dec.branch ? taken : (alu_result == 32'h0);

    assign state    = state_q;
    assign in_fetch = (state_q == S_FETCH);
    assign in_ex1   = (state_q == S_EXEC1);
    assign in_ex2   = (state_q == S_EXEC2);
    assign go       = !waitrequest;

    // Architectural writes fire only on the EXEC2 cycle that actually completes.
    assign memread   = in_fetch || (in_ex1 && dec.is_load);
    assign memwrite  = in_ex1 && dec.is_store;
    assign inwrite   = in_fetch;
    assign pctoadd   = in_fetch;
    assign pcwrite   = in_ex2 && go;
    assign regwrite  = in_ex2 && go && dec.regwrite;
    assign alusrc    = in_ex1 || (in_ex2 && dec.alusrc);
    assign regdst    = in_ex2 && dec.regdst;
    assign memtoreg  = in_ex2 && dec.memtoreg;
    assign jump      = in_ex2 && dec.jump;
    assign branch    = in_ex2 && dec.branch;
    assign regtojump = in_ex2 && dec.regtojump;
    assign link      = in_ex2 && dec.link;
    assign loadimmed = in_ex2 && dec.loadimmed;
    assign extend_op = in_ex2 ? dec.extend_op : 3'b000;

`ifdef MIPS_EXEC_MULTDIV_EN
    assign div_mult_en     = in_ex2 && go && dm_en;
    assign div_mult_signed = in_ex2 && dm_signed;
    assign div_mult_op     = in_ex2 ? dm_op : 2'b00;
    assign hitoreg         = in_ex2 && dm_hi;
    assign lotoreg         = in_ex2 && dm_lo;
`else
    assign div_mult_en     = 1'b0;
    assign div_mult_signed = 1'b0;
    assign div_mult_op     = 2'b00;
    assign hitoreg         = 1'b0;
    assign lotoreg         = 1'b0;
`endif

endmodule

// File: tb/tb_mips_exec_ctrl.sv
// Directed self-checking bench for mips_exec_ctrl: sequencing, decode/ALU vectors, stalls, halts, reset.
module tb_mips_exec_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        waitrequest;
    logic        pc_zero;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [2:0]  state;
    logic        active;
    logic [31:0] alu_result;
    logic        zero;
    logic memread, memwrite, inwrite, pcwrite, pctoadd, regwrite, regdst, memtoreg, alusrc;
    logic jump, branch, regtojump, link, loadimmed, hitoreg, lotoreg, div_mult_en, div_mult_signed;
    logic [1:0]  div_mult_op;
    logic [2:0]  extend_op;
    logic [17:0] stb;

    int total = 0;
    int bad   = 0;

    localparam logic [17:0] B_MR  = 18'h20000;  // memread
    localparam logic [17:0] B_MW  = 18'h10000;  // memwrite
    localparam logic [17:0] B_IW  = 18'h08000;  // inwrite
    localparam logic [17:0] B_PW  = 18'h04000;  // pcwrite
    localparam logic [17:0] B_PA  = 18'h02000;  // pctoadd
    localparam logic [17:0] B_RW  = 18'h01000;  // regwrite
    localparam logic [17:0] B_RD  = 18'h00800;  // regdst
    localparam logic [17:0] B_M2R = 18'h00400;  // memtoreg
    localparam logic [17:0] B_AS  = 18'h00200;  // alusrc
    localparam logic [17:0] B_J   = 18'h00100;  // jump
    localparam logic [17:0] B_BR  = 18'h00080;  // branch
    localparam logic [17:0] B_RJ  = 18'h00040;  // regtojump
    localparam logic [17:0] B_LK  = 18'h00020;  // link
    localparam logic [17:0] B_LI  = 18'h00010;  // loadimmed
    localparam logic [17:0] B_DME = 18'h00002;  // div_mult_en
    localparam logic [17:0] B_DMS = 18'h00001;  // div_mult_signed

`ifdef MIPS_EXEC_MULTDIV_EN
    localparam logic [17:0] MULT_STB = B_PW | B_DME | B_DMS;
`else
    localparam logic [17:0] MULT_STB = B_PW;
`endif

    assign stb = {memread, memwrite, inwrite, pcwrite, pctoadd, regwrite, regdst, memtoreg, alusrc,
                  jump, branch, regtojump, link, loadimmed, hitoreg, lotoreg, div_mult_en, div_mult_signed};

    always #5 clk = ~clk;

    mips_exec_ctrl dut (
        .clk(clk), .reset(reset), .waitrequest(waitrequest), .pc_zero(pc_zero),
        .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
        .state(state), .active(active), .alu_result(alu_result), .zero(zero),
        .memread(memread), .memwrite(memwrite), .inwrite(inwrite), .pcwrite(pcwrite),
        .pctoadd(pctoadd), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
        .alusrc(alusrc), .jump(jump), .branch(branch), .regtojump(regtojump), .link(link),
        .loadimmed(loadimmed), .hitoreg(hitoreg), .lotoreg(lotoreg),
        .div_mult_en(div_mult_en), .div_mult_signed(div_mult_signed),
        .div_mult_op(div_mult_op), .extend_op(extend_op)
    );

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] alu;
        logic        chk;   // alu_result/zero are defined for this instruction
        logic        z;
        logic [17:0] s2;    // EXEC2 strobes with waitrequest=0
        logic [2:0]  ext;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic to_stage(input int n, input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        instr = ins; rs_data = rs; rt_data = rt; waitrequest = 1'b0; pc_zero = 1'b0;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        repeat (n) step();
    endtask

    task automatic test_reset();
        reset = 1'b1; waitrequest = 1'b0; pc_zero = 1'b0;
        instr = 32'h0; rs_data = 32'h0; rt_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got %0d want 0", state); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL reset_active got %b want 0", active); end
        total++; if (stb !== 18'h0) begin bad++; $display("FAIL reset_strobes got %h want 0", stb); end
        reset = 1'b0;
    endtask

    task automatic test_sequence();
        logic [2:0]  seq [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
        logic [17:0] sexp[5] = '{B_MR | B_PA | B_IW, 18'h0, B_AS, B_PW | B_RW | B_RD, B_MR | B_PA | B_IW};
        instr = 32'h00221821; rs_data = 32'h1; rt_data = 32'h2;
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if (state !== seq[i]) begin bad++; $display("FAIL seq_state[%0d] got %0d want %0d", i, state, seq[i]); end
            total++; if (stb !== sexp[i]) begin bad++; $display("FAIL seq_strobes[%0d] got %h want %h", i, stb, sexp[i]); end
            if (i == 0) begin
                total++; if (active !== 1'b1) begin bad++; $display("FAIL seq_active got %b want 1", active); end
            end
        end
    endtask

    task automatic test_decode();
        vec_t        v[$];
        logic [5:0]  op;
        logic        ld;
        logic [31:0] ea;
        logic [17:0] s1;
        v.push_back('{32'h00221821, 32'hFFFFFFFF, 32'h2,        32'h1,        1'b1, 1'b0, B_PW|B_RW|B_RD, 3'b000}); // ADDU
        v.push_back('{32'h24228000, 32'h0,        32'h0,        32'hFFFF8000, 1'b1, 1'b0, B_PW|B_RW|B_AS, 3'b000}); // ADDIU
        v.push_back('{32'h34228000, 32'h0,        32'h0,        32'h00008000, 1'b1, 1'b0, B_PW|B_RW|B_AS, 3'b000}); // ORI
        v.push_back('{32'h30228000, 32'hFFFFFFFF, 32'h0,        32'h00008000, 1'b1, 1'b0, B_PW|B_RW|B_AS, 3'b000}); // ANDI
        v.push_back('{32'h38228000, 32'hFFFFFFFF, 32'h0,        32'hFFFF7FFF, 1'b1, 1'b0, B_PW|B_RW|B_AS, 3'b000}); // XORI
        v.push_back('{32'h3C021234, 32'h0,        32'h0,        32'h12340000, 1'b1, 1'b0, B_PW|B_RW|B_AS|B_LI, 3'b000}); // LUI
        v.push_back('{32'h0022182A, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b1, 1'b0, B_PW|B_RW|B_RD, 3'b000}); // SLT
        v.push_back('{32'h0022182B, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b1, B_PW|B_RW|B_RD, 3'b000}); // SLTU
        v.push_back('{32'h00221823, 32'h5,        32'h5,        32'h0,        1'b1, 1'b1, B_PW|B_RW|B_RD, 3'b000}); // SUBU
        v.push_back('{32'h00221827, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b1, 1'b0, B_PW|B_RW|B_RD, 3'b000}); // NOR
        v.push_back('{32'h00021903, 32'h0,        32'h80000000, 32'hF8000000, 1'b1, 1'b0, B_PW|B_RW|B_RD, 3'b000}); // SRA 4
        v.push_back('{32'h00221806, 32'h4,        32'h80000000, 32'h08000000, 1'b1, 1'b0, B_PW|B_RW|B_RD, 3'b000}); // SRLV
        v.push_back('{32'h04210004, 32'h0,        32'h0,        32'h0,        1'b0, 1'b1, B_PW|B_BR, 3'b000});      // BGEZ
        v.push_back('{32'h04200004, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0, B_PW|B_BR, 3'b000});      // BLTZ
        v.push_back('{32'h10220004, 32'h5,        32'h5,        32'h0,        1'b0, 1'b1, B_PW|B_BR, 3'b000});      // BEQ
        v.push_back('{32'h14220004, 32'h5,        32'h5,        32'h0,        1'b0, 1'b0, B_PW|B_BR, 3'b000});      // BNE
        v.push_back('{32'h18200004, 32'h0,        32'h0,        32'h0,        1'b0, 1'b1, B_PW|B_BR, 3'b000});      // BLEZ
        v.push_back('{32'h1C200004, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0, B_PW|B_BR, 3'b000});      // BGTZ
        v.push_back('{32'h04310004, 32'hFFFFFFFF, 32'h0,        32'h0,        1'b0, 1'b0, B_PW|B_BR|B_LK|B_RW, 3'b000}); // BGEZAL
        v.push_back('{32'h04300004, 32'hFFFFFFFF, 32'h0,        32'h0,        1'b0, 1'b1, B_PW|B_BR|B_LK|B_RW, 3'b000}); // BLTZAL
        v.push_back('{32'h0C000010, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0, B_PW|B_J|B_LK|B_RW, 3'b000});  // JAL
        v.push_back('{32'h00200008, 32'h40,       32'h0,        32'h0,        1'b0, 1'b0, B_PW|B_J|B_RJ, 3'b000});       // JR
        v.push_back('{32'h0020F809, 32'h40,       32'h0,        32'h0,        1'b0, 1'b0, B_PW|B_J|B_RJ|B_RW|B_RD, 3'b000}); // JALR
        v.push_back('{32'h8022FFFC, 32'h100,      32'h0,        32'hFC,       1'b1, 1'b0, B_PW|B_RW|B_AS, 3'b111});       // LB
        v.push_back('{32'h9422FFFC, 32'h100,      32'h0,        32'hFC,       1'b1, 1'b0, B_PW|B_RW|B_AS, 3'b100});       // LHU
        v.push_back('{32'h8C22FFFC, 32'h100,      32'h0,        32'hFC,       1'b1, 1'b0, B_PW|B_RW|B_AS|B_M2R, 3'b000}); // LW
        v.push_back('{32'hAC22FFFC, 32'h100,      32'h0,        32'hFC,       1'b1, 1'b0, B_PW|B_AS, 3'b000});            // SW
        v.push_back('{32'hFC000000, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0, B_PW, 3'b000});                 // unknown
        v.push_back('{32'h00220018, 32'h3,        32'h4,        32'h0,        1'b0, 1'b0, MULT_STB, 3'b000});             // MULT
        foreach (v[i]) begin
            op = v[i].ins[31:26];
            ld = (op == 6'h20) || (op == 6'h21) || (op == 6'h23) || (op == 6'h24) || (op == 6'h25);
            s1 = B_AS | (ld ? B_MR : 18'h0) | ((op == 6'h2b) ? B_MW : 18'h0);
            ea = v[i].rs + {{16{v[i].ins[15]}}, v[i].ins[15:0]};
            to_stage(3, v[i].ins, v[i].rs, v[i].rt);
            total++; if (stb !== s1) begin bad++; $display("FAIL ex1_strobes[%0d] %h got %h want %h", i, v[i].ins, stb, s1); end
            total++; if (alu_result !== ea) begin bad++; $display("FAIL ex1_addr[%0d] %h got %h want %h", i, v[i].ins, alu_result, ea); end
            step();
            total++; if (stb !== v[i].s2) begin bad++; $display("FAIL ex2_strobes[%0d] %h got %h want %h", i, v[i].ins, stb, v[i].s2); end
            total++; if (extend_op !== v[i].ext) begin bad++; $display("FAIL ex2_extend[%0d] %h got %b want %b", i, v[i].ins, extend_op, v[i].ext); end
            if (v[i].chk) begin
                total++; if (alu_result !== v[i].alu) begin bad++; $display("FAIL ex2_alu[%0d] %h got %h want %h", i, v[i].ins, alu_result, v[i].alu); end
            end
            if (v[i].chk || v[i].s2[7]) begin
                total++; if (zero !== v[i].z) begin bad++; $display("FAIL ex2_zero[%0d] %h got %b want %b", i, v[i].ins, zero, v[i].z); end
            end
        end
    endtask

    task automatic test_wait_stall();
        to_stage(4, 32'h00221821, 32'hFFFFFFFF, 32'h2);
        waitrequest = 1'b1;
        #1;
        total++; if ({regwrite, pcwrite} !== 2'b00) begin bad++; $display("FAIL stall_hold got %b want 00", {regwrite, pcwrite}); end
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (state !== 3'd4) begin bad++; $display("FAIL stall_state[%0d] got %0d want 4", i, state); end
            total++; if ({regwrite, pcwrite} !== 2'b00) begin bad++; $display("FAIL stall_strobes[%0d] got %b want 00", i, {regwrite, pcwrite}); end
        end
        waitrequest = 1'b0;
        #1;
        total++; if ({regwrite, pcwrite} !== 2'b11) begin bad++; $display("FAIL stall_release got %b want 11", {regwrite, pcwrite}); end
        step();
        total++; if (state !== 3'd1) begin bad++; $display("FAIL stall_next got %0d want 1", state); end
    endtask

    task automatic test_pc_zero();
        to_stage(2, 32'h00221821, 32'h1, 32'h2);
        pc_zero = 1'b1;
        waitrequest = 1'b1;
        step();
        total++; if (state !== 3'd0) begin bad++; $display("FAIL pczero_state got %0d want 0", state); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL pczero_active got %b want 0", active); end
        pc_zero = 1'b0;
        waitrequest = 1'b0;
    endtask

    task automatic test_reset_mid();
        to_stage(4, 32'h00221821, 32'hFFFFFFFF, 32'h2);
        waitrequest = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        total++; if (state !== 3'd0) begin bad++; $display("FAIL midrst_state got %0d want 0", state); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL midrst_active got %b want 0", active); end
        waitrequest = 1'b0;
        #1;
        total++; if (stb !== 18'h0) begin bad++; $display("FAIL midrst_strobes got %h want 0", stb); end
        reset = 1'b0;
        step();
        total++; if (state !== 3'd1) begin bad++; $display("FAIL midrst_restart got %0d want 1", state); end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_decode();
        test_wait_stall();
        test_pc_zero();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_exec_ctrl.md
MIPS_EXEC_CTRL -- requirements
Module: mips_exec_ctrl

Interface
REQ-001 The block SHALL have ports: clk in 1, rising-edge clock; reset in 1, asynchronous active-high reset; waitrequest in 1, bus stall; pc_zero in 1, PC equals 0; instr in 32, current instruction; rs_data in 32; rt_data in 32.
REQ-002 The block SHALL have outputs: state out 3 (0 HALT, 1 FETCH, 2 DECODE, 3 EXEC1, 4 EXEC2); active out 1; alu_result out 32; zero out 1, branch-taken/equal flag.
REQ-003 The block SHALL have 1-bit strobe outputs memread, memwrite, inwrite, pcwrite, pctoadd, regwrite, regdst, memtoreg, alusrc, jump, branch, regtojump, link, loadimmed, hitoreg, lotoreg, div_mult_en, div_mult_signed, plus div_mult_op out 2 and extend_op out 3.

Function
REQ-004 The FSM SHALL advance only on clk edges with waitrequest=0: HALT->FETCH (active<=1), FETCH->DECODE->EXEC1->EXEC2->FETCH.
REQ-005 When pc_zero=1 and state!=HALT, the next edge SHALL force HALT and active<=0, taking priority over advance, regardless of waitrequest.
REQ-006 FETCH SHALL assert memread, pctoadd, inwrite; all other strobes 0.
REQ-007 EXEC1 SHALL assert memread (loads) or memwrite (SW), with pctoadd=0, alusrc=1, ALU = rs+signext(imm).
REQ-008 EXEC2 SHALL assert pcwrite, and regwrite for register-writing instructions, only while waitrequest=0; HALT and DECODE assert no strobes.
REQ-009 Decode SHALL be combinational from instr[31:26], funct instr[5:0], instr[20:16]; unsupported encodings behave as NOP (pcwrite only).
REQ-010 R-type SHALL set regdst=1, alusrc=0: ADDU, SUBU, AND, OR, XOR, NOR, SLT (signed), SLTU, SLL/SRL/SRA (shamt instr[10:6]), SLLV/SRLV/SRAV (amount rs[4:0]).
REQ-011 I-type SHALL set regdst=0, alusrc=1: ADDIU, SLTI, SLTIU use sign-extended imm; ANDI, ORI, XORI use zero-extended imm; LUI sets loadimmed.
REQ-012 LW SHALL set memtoreg; LB/LBU/LH/LHU SHALL set extend_op 111/110/101/100 respectively, memtoreg=0; all others extend_op=000.
REQ-013 Branches SHALL set branch=1; zero=1 iff taken: BEQ rs==rt, BNE rs!=rt, BLEZ rs<=0, BGTZ rs>0, BLTZ rs<0, BGEZ rs>=0 (signed; REGIMM by instr[20:16]).
REQ-014 BLTZAL/BGEZAL SHALL additionally set link=1, regwrite=1 regardless of outcome.
REQ-015 J/JAL SHALL set jump; JAL adds link, regwrite; JR/JALR set jump, regtojump; JALR adds regwrite, regdst=1.
REQ-016 Non-branch instructions SHALL drive zero=(alu_result==0).
REQ-017 Arithmetic SHALL wrap modulo 2^32 with no overflow traps.

Reset
REQ-018 reset SHALL immediately force state=HALT, active=0; all strobes are then 0.
REQ-019 Reset asserted mid-instruction SHALL abandon the instruction with no further register or PC write.

Configuration
REQ-020 With MIPS_EXEC_MULTDIV_EN defined, MULT/MULTU/DIV/DIVU SHALL assert div_mult_en in EXEC2 (div_mult_signed=1 for MULT/DIV; div_mult_op 00 mult, 01 div, 10 MTHI, 11 MTLO), and MFHI/MFLO SHALL set hitoreg/lotoreg, regwrite, regdst=1.
REQ-021 Without MIPS_EXEC_MULTDIV_EN, those encodings SHALL decode as NOP with div_mult_en, hitoreg, lotoreg tied 0.

Verification
REQ-022 Reset, release, waitrequest=0 -> state 0,1,2,3,4,1 on successive edges; active=1 after first edge.
REQ-023 ADDU with rs=0xFFFFFFFF, rt=2 in EXEC2 -> alu_result=1, regwrite=1, regdst=1, pcwrite=1.
REQ-024 ADDIU imm=0x8000, rs=0 -> alu_result=0xFFFF8000; ORI same imm -> 0x00008000.
REQ-025 BGEZ rs=0 -> branch=1, zero=1; BLTZ rs=0 -> zero=0; SLT rs=-1, rt=1 -> 1; SLTU -> 0.
REQ-026 waitrequest=1 held in EXEC2 for 3 cycles -> state stays 4, regwrite and pcwrite 0 until release.
REQ-027 pc_zero=1 in DECODE -> next edge state=0, active=0.
